// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between NUM_REQ requesters, the arbiter and the FIFO write port.
// The master modport is the arbiter's view; slave is the requester/FIFO environment.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        gnt;
    logic                      f_full_flag;
    logic                      f_almost_full_flag;
    logic                      w_en;
    logic [DATA_W-1:0]         d_in;
    logic                      busy;
    logic [OWNER_W-1:0]        owner;

    modport master (
        input  req, req_data, req_last, f_full_flag, f_almost_full_flag,
        output gnt, w_en, d_in, busy, owner
    );

    modport slave (
        output req, req_data, req_last, f_full_flag, f_almost_full_flag,
        input  gnt, w_en, d_in, busy, owner
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NUM_REQ requesters.
// One IDLE arbitration cycle per burst; beats are registered onto w_en/d_in one cycle after gnt.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_write_arbiter_if.master  bus
);
    localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_w_en;
    logic [DATA_W-1:0]   r_d_in;
    logic                r_busy;
    logic [OWNER_W-1:0]  r_owner;
    logic [OWNER_W-1:0]  r_last_owner;
    logic [CNT_W-1:0]    r_beat_cnt;

    logic [OWNER_W:0]    w_sum  [NUM_REQ];
    logic [OWNER_W-1:0]  w_cand [NUM_REQ];
    logic [OWNER_W-1:0]  w_arb_owner;
    logic                w_any_req;
    logic                w_can_accept;
    logic                w_accept;
    logic                w_release;
    logic [DATA_W-1:0]   w_owner_data;

    // Candidate k is last_owner+1+k modulo NUM_REQ; the extra bit keeps the wrap exact for any NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign w_sum[gi]  = {1'b0, r_last_owner} + (OWNER_W+1)'(gi + 1);
        assign w_cand[gi] = (w_sum[gi] >= (OWNER_W+1)'(NUM_REQ))
                          ? OWNER_W'(w_sum[gi] - (OWNER_W+1)'(NUM_REQ))
                          : w_sum[gi][OWNER_W-1:0];
    end

    always_comb begin
        w_arb_owner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[w_cand[k]]) begin
                w_arb_owner = w_cand[k];
            end
        end
    end

    always_comb begin
        w_owner_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner == OWNER_W'(k)) begin
                w_owner_data = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_any_req = |bus.req;
    // A write already registered may take the last free slot, so almost-full blocks a second one.
    assign w_can_accept = !bus.f_full_flag && !(bus.f_almost_full_flag && r_w_en);
    assign w_accept = (r_state == BURST) && !reset && bus.req[r_owner] && w_can_accept;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
        assign bus.gnt[gi] = w_accept && (r_owner == OWNER_W'(gi));
    end

    always_comb begin
        w_state_next = r_state;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next = BURST;
                end
            end
            BURST: begin
                w_release = !bus.req[r_owner]
                         || (w_accept && (bus.req_last[r_owner]
                                          || r_beat_cnt == CNT_W'(MAX_BURST - 1)));
                if (w_release) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_en       <= 1'b0;
            r_d_in       <= '0;
            r_busy       <= 1'b0;
            r_owner      <= '0;
            r_beat_cnt   <= '0;
            r_last_owner <= OWNER_W'(NUM_REQ - 1);
        end else begin
            r_w_en <= w_accept;
            if (w_accept) begin
                r_d_in     <= w_owner_data;
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (r_state == IDLE && w_any_req) begin
                r_owner    <= w_arb_owner;
                r_busy     <= 1'b1;
                r_beat_cnt <= '0;
            end
            if (w_release) begin
                r_last_owner <= r_owner;
                r_busy       <= 1'b0;
            end
        end
    end

    assign bus.w_en  = r_w_en;
    assign bus.d_in  = r_d_in;
    assign bus.busy  = r_busy;
    assign bus.owner = r_owner;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle gnt/busy/owner/w_en expectations,
// plus a queue of expected FIFO writes checked whenever w_en is seen high.
module tb_fifo_write_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    exp_q [$];
    logic [7:0]    src_d [NR][16];
    logic          src_l [NR][16];
    int            src_n [NR];
    int            src_p [NR];
    logic [NR-1:0] en;

    logic [NR-1:0] s_gnt;
    logic          s_busy;
    logic          s_w_en;
    logic [1:0]    s_owner;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic add(input int r, input logic [7:0] d, input logic l);
        src_d[r][src_n[r]] = d;
        src_l[r][src_n[r]] = l;
        src_n[r]++;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        en = '0;
    endtask

    // Present each enabled requester's current beat, sample at negedge, retire granted beats.
    task automatic tick(input logic [NR-1:0] eg, input string tag);
        for (int i = 0; i < NR; i++) begin
            if (en[i] && src_p[i] < src_n[i]) begin
                bus.req[i]                = 1'b1;
                bus.req_data[i*DW +: DW]  = src_d[i][src_p[i]];
                bus.req_last[i]           = src_l[i][src_p[i]];
            end else begin
                bus.req[i]      = 1'b0;
                bus.req_last[i] = 1'b0;
            end
        end
        @(negedge clk);
        s_gnt   = bus.gnt;
        s_busy  = bus.busy;
        s_w_en  = bus.w_en;
        s_owner = bus.owner;
        $display("tick %s: gnt=%b busy=%b owner=%0d w_en=%b d_in=%h", tag, s_gnt, s_busy, s_owner, s_w_en, bus.d_in);
        chk(tag, 32'(s_gnt), 32'(eg));
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (s_gnt[i]) src_p[i]++;
        end
    endtask

    always @(negedge clk) begin
        if (bus.w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(bus.d_in), 32'hFFFF_FFFF);
            end else begin
                chk("wr_data", 32'(bus.d_in), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset                  = 1'b1;
        bus.req                = '0;
        bus.req_data           = '0;
        bus.req_last           = '0;
        bus.f_full_flag        = 1'b0;
        bus.f_almost_full_flag = 1'b0;
        clear_src();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_w_en",  32'(bus.w_en),  0);
        chk("rst_d_in",  32'(bus.d_in),  0);
        chk("rst_busy",  32'(bus.busy),  0);
        chk("rst_owner", 32'(bus.owner), 0);
        chk("rst_gnt",   32'(bus.gnt),   0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All four requesting, no req_last: 4-beat bursts in order 0,1,2,3,0
        clear_src();
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 4; k++) add(r, 8'(16*(r+1) + k), 1'b0);
        for (int k = 4; k < 8; k++) add(0, 8'(16 + k), 1'b0);
        for (int b = 0; b < 5; b++)
            for (int j = 0; j < 4; j++) exp_q.push_back(8'(16*((b%4)+1) + (b/4)*4 + j));
        en = 4'hF;
        for (int b = 0; b < 5; b++) begin
            tick('0, $sformatf("t2_idle%0d", b));
            chk($sformatf("t2_busy_idle%0d", b), 32'(s_busy), 0);
            for (int j = 0; j < 4; j++) begin
                tick(NR'(1 << (b % 4)), $sformatf("t2_b%0d_j%0d", b, j));
                chk($sformatf("t2_owner%0d_%0d", b, j), 32'(s_owner), 32'(b % 4));
                chk($sformatf("t2_busy%0d_%0d", b, j), 32'(s_busy), 1);
            end
        end
        tick('0, "t2_end");

        // Single requester 2, three beats
        clear_src();
        add(2, 8'hA1, 1'b0); add(2, 8'hA2, 1'b0); add(2, 8'hA3, 1'b1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        en = 4'b0100;
        tick('0, "t1_arb");        chk("t1_busy0", 32'(s_busy), 0);
        tick(4'b0100, "t1_g1");    chk("t1_owner", 32'(s_owner), 2); chk("t1_wen1", 32'(s_w_en), 0);
        tick(4'b0100, "t1_g2");    chk("t1_wen2", 32'(s_w_en), 1);
        tick(4'b0100, "t1_g3");    chk("t1_busy3", 32'(s_busy), 1);
        tick('0, "t1_after");      chk("t1_busy4", 32'(s_busy), 0); chk("t1_wen4", 32'(s_w_en), 1);
        tick('0, "t1_tail");       chk("t1_wen5", 32'(s_w_en), 0);

        // Full stall for 5 cycles in the middle of a burst
        clear_src();
        for (int k = 0; k < 4; k++) add(1, 8'(8'h30 + k), 1'b0);
        add(1, 8'h34, 1'b1);
        for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h30 + k));
        en = 4'b0010;
        tick('0, "t3_arb");
        tick(4'b0010, "t3_b0");
        bus.f_full_flag = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick('0, $sformatf("t3_full%0d", k));
            chk($sformatf("t3_wen%0d", k), 32'(s_w_en), (k == 0) ? 1 : 0);
            chk($sformatf("t3_busy%0d", k), 32'(s_busy), 1);
        end
        bus.f_full_flag = 1'b0;
        tick(4'b0010, "t3_b1");
        tick(4'b0010, "t3_b2");
        tick(4'b0010, "t3_b3");
        tick('0, "t3_rearb");
        tick(4'b0010, "t3_b4");
        tick('0, "t3_end");

        // Almost-full with a write in flight
        clear_src();
        add(3, 8'h40, 1'b0); add(3, 8'h41, 1'b0); add(3, 8'h42, 1'b1);
        exp_q.push_back(8'h40); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        en = 4'b1000;
        tick('0, "t4_arb");
        tick(4'b1000, "t4_b0");
        bus.f_almost_full_flag = 1'b1;
        tick('0, "t4_af_wen");      chk("t4_wen_a", 32'(s_w_en), 1);
        tick(4'b1000, "t4_af_b1");  chk("t4_wen_b", 32'(s_w_en), 0);
        tick('0, "t4_af_wen2");     chk("t4_wen_c", 32'(s_w_en), 1);
        bus.f_almost_full_flag = 1'b0;
        tick(4'b1000, "t4_b2");
        tick('0, "t4_end");

        // Owner withdraws after one beat; next owner searched from owner+1
        clear_src();
        for (int k = 0; k < 4; k++) add(1, 8'(8'h50 + k), 1'b0);
        add(2, 8'h60, 1'b0); add(2, 8'h61, 1'b1);
        add(0, 8'h70, 1'b1);
        exp_q.push_back(8'h50); exp_q.push_back(8'h60); exp_q.push_back(8'h61); exp_q.push_back(8'h70);
        en = 4'b0010;
        tick('0, "t5_arb");
        en = 4'b0111;
        tick(4'b0010, "t5_b0");
        en[1] = 1'b0;
        tick('0, "t5_drop");        chk("t5_busy_drop", 32'(s_busy), 1);
        tick('0, "t5_idle");        chk("t5_busy_idle", 32'(s_busy), 0); chk("t5_wen_idle", 32'(s_w_en), 0);
        tick(4'b0100, "t5_r2b0");   chk("t5_owner", 32'(s_owner), 2);
        tick(4'b0100, "t5_r2b1");
        tick('0, "t5_rearb");
        tick(4'b0001, "t5_r0b0");
        tick('0, "t5_end");

        // Reset mid-burst, then requester 0 wins over 3
        clear_src();
        add(3, 8'h80, 1'b0); add(3, 8'h81, 1'b0); add(3, 8'h82, 1'b0); add(3, 8'h83, 1'b1);
        add(0, 8'h90, 1'b1);
        exp_q.push_back(8'h80); exp_q.push_back(8'h81); exp_q.push_back(8'h90);
        exp_q.push_back(8'h82); exp_q.push_back(8'h83);
        en = 4'b1000;
        tick('0, "t6_arb");
        tick(4'b1000, "t6_b0");
        tick(4'b1000, "t6_b1");
        reset = 1'b1;
        en    = 4'b1001;
        tick('0, "t6_rst");         chk("t6_wen_rst", 32'(s_w_en), 1);
        reset = 1'b0;
        tick('0, "t6_post");
        chk("t6_wen_post",   32'(s_w_en),  0);
        chk("t6_busy_post",  32'(s_busy),  0);
        chk("t6_owner_post", 32'(s_owner), 0);
        tick(4'b0001, "t6_r0");
        tick('0, "t6_rearb");
        tick(4'b1000, "t6_b2");
        tick(4'b1000, "t6_b3");
        tick('0, "t6_end");
        tick('0, "t6_drain");

        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
